// File: rtl/decoder.sv
// RV32I decode stage: splits fetched instructions into fields and op class,
// holding the result in one registered slot with a valid/ready handoff.
module decoder #(
  parameter bit ALLOW_FENCE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetcher_valid,
  input  logic [31:0] instr,
  input  logic [31:0] fetcher_pc,
  output logic        decoder_ready,
  input  logic        flush,
  input  logic        executor_ready,
  output logic        decoder_valid,
  output logic [31:0] dec_pc,
  output logic [3:0]  dec_op,
  output logic [2:0]  dec_funct3,
  output logic        dec_alt,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [4:0]  dec_rd,
  output logic [31:0] dec_imm,
  output logic        dec_illegal
);

  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_LUI     = 4'd1,
    OP_AUIPC   = 4'd2,
    OP_JAL     = 4'd3,
    OP_JALR    = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_LOAD    = 4'd6,
    OP_STORE   = 4'd7,
    OP_OPIMM   = 4'd8,
    OP_OP      = 4'd9,
    OP_FENCE   = 4'd10,
    OP_SYSTEM  = 4'd11
  } op_e;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        shift;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign shift = (f3 == 3'd1) || (f3 == 3'd5);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  op_e         op_d;
  logic [2:0]  f3_d;
  logic        alt_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] imm_d;

  always_comb begin
    op_d  = OP_ILLEGAL;
    rs1_d = instr[19:15];
    rs2_d = '0;
    rd_d  = instr[11:7];
    imm_d = '0;
    alt_d = 1'b0;
    f3_d  = f3;
    case (opc)
      7'h37: begin op_d = OP_LUI;   rs1_d = '0; imm_d = imm_u; end
      7'h17: begin op_d = OP_AUIPC; rs1_d = '0; imm_d = imm_u; end
      7'h6f: begin op_d = OP_JAL;   rs1_d = '0; imm_d = imm_j; end
      7'h67: if (f3 == 3'd0) begin
        op_d  = OP_JALR;
        imm_d = imm_i;
      end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        op_d  = OP_BRANCH;
        rs2_d = instr[24:20];
        rd_d  = '0;
        imm_d = imm_b;
      end
      7'h03: if (f3 != 3'd3 && f3 < 3'd6) begin
        op_d  = OP_LOAD;
        imm_d = imm_i;
      end
      7'h23: if (f3 <= 3'd2) begin
        op_d  = OP_STORE;
        rs2_d = instr[24:20];
        rd_d  = '0;
        imm_d = imm_s;
      end
      7'h13: if (!shift || f7 == 7'h00 ||
                 (f3 == 3'd5 && f7 == 7'h20)) begin
        op_d  = OP_OPIMM;
        imm_d = imm_i;
        alt_d = shift & instr[30];
      end
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 &&
                 (f3 == 3'd0 || f3 == 3'd5))) begin
        op_d  = OP_OP;
        rs2_d = instr[24:20];
        alt_d = instr[30];
      end
      7'h0f: if (ALLOW_FENCE) begin
        op_d  = OP_FENCE;
        rd_d  = '0;
        imm_d = imm_i;
      end
      7'h73: if (f3 != 3'd4) begin
        op_d  = OP_SYSTEM;
        imm_d = imm_i;
      end
      default: ;
    endcase
    // Illegal encodings carry no operands, only their PC.
    if (op_d == OP_ILLEGAL) begin
      rs1_d = '0;
      rs2_d = '0;
      rd_d  = '0;
      imm_d = '0;
      alt_d = 1'b0;
      f3_d  = '0;
    end
  end

  logic valid_q, ill_q, alt_q;
  logic [31:0] pc_q, imm_q;
  logic [3:0]  op_q;
  logic [2:0]  f3_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic        capture, handoff;

  assign decoder_ready = !valid_q || executor_ready;
  assign capture = fetcher_valid && decoder_ready && !flush;
  assign handoff = valid_q && executor_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      op_q    <= '0;
      f3_q    <= '0;
      alt_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      pc_q    <= fetcher_pc;
      op_q    <= op_d;
      f3_q    <= f3_d;
      alt_q   <= alt_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      ill_q   <= (op_d == OP_ILLEGAL);
    end else if (handoff) begin
      valid_q <= 1'b0;
    end
  end

  assign decoder_valid = valid_q;
  assign dec_pc        = pc_q;
  assign dec_op        = op_q;
  assign dec_funct3    = f3_q;
  assign dec_alt       = alt_q;
  assign dec_rs1       = rs1_q;
  assign dec_rs2       = rs2_q;
  assign dec_rd        = rd_q;
  assign dec_imm       = imm_q;
  assign dec_illegal   = ill_q;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: directed cases plus random traffic scored against
// an arithmetic reference model through an expected-result queue.
module tb_decoder;

  logic        clk, reset, fetcher_valid, flush, executor_ready;
  logic [31:0] instr, fetcher_pc;
  logic        decoder_ready, decoder_valid, dec_alt, dec_illegal;
  logic [31:0] dec_pc, dec_imm;
  logic [3:0]  dec_op;
  logic [2:0]  dec_funct3;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;

  decoder #(.ALLOW_FENCE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .fetcher_valid(fetcher_valid), .instr(instr),
    .fetcher_pc(fetcher_pc), .decoder_ready(decoder_ready),
    .flush(flush), .executor_ready(executor_ready),
    .decoder_valid(decoder_valid), .dec_pc(dec_pc),
    .dec_op(dec_op), .dec_funct3(dec_funct3),
    .dec_alt(dec_alt), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm(dec_imm), .dec_illegal(dec_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic exp_t model(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    int f3, f7, op, v;
    logic [31:0] iI, iS, iB, iU, iJ;
    e = '0;
    e.pc = pc;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    v  = int'(w[30:20]) - int'(w[31]) * 2048;
    iI = 32'(v);
    v  = int'(w[30:25]) * 32 + int'(w[11:7]) - int'(w[31]) * 2048;
    iS = 32'(v);
    v  = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
         - int'(w[31]) * 4096;
    iB = 32'(v);
    iU = w & 32'hFFFF_F000;
    v  = int'(w[19:12]) * 4096 + int'(w[20]) * 2048
         + int'(w[30:21]) * 2 - int'(w[31]) * (1 << 20);
    iJ = 32'(v);
    case (w[6:0])
      7'h37: op = 1;
      7'h17: op = 2;
      7'h6f: op = 3;
      7'h67: op = (f3 == 0) ? 4 : 0;
      7'h63: op = (f3 == 2 || f3 == 3) ? 0 : 5;
      7'h03: op = (f3 == 3 || f3 >= 6) ? 0 : 6;
      7'h23: op = (f3 > 2) ? 0 : 7;
      7'h13: op = ((f3 == 1 && f7 != 0) ||
                   (f3 == 5 && f7 != 0 && f7 != 32)) ? 0 : 8;
      7'h33: op = (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))
                  ? 9 : 0;
      7'h0f: op = 10;
      7'h73: op = (f3 == 4) ? 0 : 11;
      default: op = 0;
    endcase
    if (op == 0) return e;
    e.op  = 4'(op);
    e.f3  = w[14:12];
    e.rs1 = (op inside {1, 2, 3}) ? 5'd0 : w[19:15];
    e.rs2 = (op inside {5, 7, 9}) ? w[24:20] : 5'd0;
    e.rd  = (op inside {5, 7, 10}) ? 5'd0 : w[11:7];
    case (op)
      1, 2:    e.imm = iU;
      3:       e.imm = iJ;
      5:       e.imm = iB;
      7:       e.imm = iS;
      9:       e.imm = 32'd0;
      default: e.imm = iI;
    endcase
    e.alt = (op == 9 || (op == 8 && (f3 == 1 || f3 == 5))) ? w[30] : 1'b0;
    return e;
  endfunction

  function automatic void cmp(exp_t e);
    chk("pc", dec_pc, e.pc);
    chk("op", dec_op, e.op);
    chk("funct3", dec_funct3, e.f3);
    chk("alt", dec_alt, e.alt);
    chk("rs1", dec_rs1, e.rs1);
    chk("rs2", dec_rs2, e.rs2);
    chk("rd", dec_rd, e.rd);
    chk("imm", dec_imm, e.imm);
    chk("illegal", dec_illegal, e.op == 4'd0);
  endfunction

  // Issue side: the model result is queued when the slot accepts.
  always @(posedge clk) begin
    if (!reset) begin
      if (flush) q.delete();
      else if (fetcher_valid && (q.size() == 0 || executor_ready))
        q.push_back(model(instr, fetcher_pc));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", decoder_valid, q.size() != 0);
      chk("ready", decoder_ready, q.size() == 0 || executor_ready);
      if (decoder_valid && q.size() != 0) begin
        cmp(q[0]);
        if (executor_ready) void'(q.pop_front());
      end
    end
  end

  task automatic drive(logic fv, logic [31:0] w, logic [31:0] pc,
                       logic er, logic fl);
    fetcher_valid  = fv;
    instr          = w;
    fetcher_pc     = pc;
    executor_ready = er;
    flush          = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFB10093;
  localparam logic [31:0] SW   = 32'h00532423;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;

  initial begin
    reset = 1'b1;
    fetcher_valid = 1'b0;
    instr = '0;
    fetcher_pc = '0;
    flush = 1'b0;
    executor_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", decoder_valid, 1'b0);
    chk("rst_op", dec_op, 4'd0);
    chk("rst_imm", dec_imm, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", decoder_ready, 1'b1);

    drive(1, ADDI, 32'h100, 1, 0);
    chk("addi_op", dec_op, 4'd8);
    chk("addi_rs1", dec_rs1, 5'd2);
    chk("addi_rd", dec_rd, 5'd1);
    chk("addi_rs2", dec_rs2, 5'd0);
    chk("addi_imm", dec_imm, 32'hFFFFFFFB);
    chk("addi_pc", dec_pc, 32'h100);
    chk("addi_ill", dec_illegal, 1'b0);

    drive(1, SW, 32'h104, 1, 0);
    chk("sw_op", dec_op, 4'd7);
    chk("sw_rs1", dec_rs1, 5'd6);
    chk("sw_rs2", dec_rs2, 5'd5);
    chk("sw_rd", dec_rd, 5'd0);
    chk("sw_imm", dec_imm, 32'd8);

    drive(1, BEQ, 32'h108, 1, 0);
    chk("beq_op", dec_op, 4'd5);
    chk("beq_imm", dec_imm, 32'hFFFFFFFC);

    drive(1, ADDI, 32'h200, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, SW, 32'h300, 0, 0);
      chk("stall_ready", decoder_ready, 1'b0);
      chk("stall_pc", dec_pc, 32'h200);
      chk("stall_op", dec_op, 4'd8);
    end
    drive(1, SW, 32'h300, 1, 0);
    chk("unstall_pc", dec_pc, 32'h300);
    chk("unstall_op", dec_op, 4'd7);

    drive(1, 32'h0, 32'h400, 1, 0);
    chk("ill0_valid", decoder_valid, 1'b1);
    chk("ill0_op", dec_op, 4'd0);
    chk("ill0_flag", dec_illegal, 1'b1);
    chk("ill0_pc", dec_pc, 32'h400);
    drive(1, 32'h4000F033, 32'h404, 1, 0);
    chk("ill_op_flag", dec_illegal, 1'b1);
    chk("ill_op_rd", dec_rd, 5'd0);

    drive(1, ADDI, 32'h500, 1, 1);
    chk("flush_valid", decoder_valid, 1'b0);
    drive(1, ADDI, 32'h504, 1, 0);
    drive(1, SW, 32'h508, 0, 1);
    chk("flush_stall_valid", decoder_valid, 1'b0);

    drive(1, ADDI, 32'h600, 0, 0);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("arst_valid", decoder_valid, 1'b0);
    chk("arst_op", dec_op, 4'd0);
    chk("arst_rs1", dec_rs1, 5'd0);
    chk("arst_imm", dec_imm, 32'd0);
    chk("arst_pc", dec_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_ready", decoder_ready, 1'b1);

    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 3) != 0, rand_instr(),
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    chk("drain_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- RV32I decode stage. Sits directly downstream of the fetch stage and consumes its `instr` / `fetcher_pc` / `fetcher_valid` outputs.
- Drives `decoder_ready` back to fetch.
- Splits each instruction into register indices, a sign-extended immediate and an op class. Flags illegal encodings.
- Holds the result in a single registered output slot, with a valid/ready handshake to the execute stage.

Parameters:
- ALLOW_FENCE, default 1: 1 = FENCE/FENCE.I decode as OP_FENCE; 0 = they decode as illegal.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- fetcher_valid  input  1  upstream instruction available
- instr  input  32  instruction word from fetch
- fetcher_pc  input  32  PC of `instr`
- decoder_ready  output  1  decode can accept an instruction this cycle
- flush  input  1  redirect from execute; drop held and incoming instructions
- executor_ready  input  1  execute accepts the held instruction this cycle
- decoder_valid  output  1  output slot holds a decoded instruction
- dec_pc  output  32  PC of held instruction
- dec_op  output  4  0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP, 10 FENCE, 11 SYSTEM
- dec_funct3  output  3  instr[14:12]
- dec_alt  output  1  instr[30] for OP, and for OP_IMM shifts (SUB/SRA/SRAI); 0 otherwise
- dec_rs1  output  5  rs1 index; 0 for LUI, AUIPC, JAL
- dec_rs2  output  5  rs2 index; 0 unless BRANCH, STORE or OP
- dec_rd  output  5  rd index; 0 for BRANCH, STORE, FENCE
- dec_imm  output  32  sign-extended immediate for I/S/B/U/J formats; 0 for OP
- dec_illegal  output  1  held instruction is illegal (equals dec_op==0)

Behaviour:
- Reset (asynchronous, active-high), applied immediately whenever `reset` is high:
  - decoder_valid = 0.
  - All dec_* outputs = 0.
  - No handshake is honoured while `reset` is high.
- Handshake:
  - decoder_ready = !decoder_valid || executor_ready (combinational).
  - Capture = fetcher_valid && decoder_ready && !flush.
  - Handoff = decoder_valid && executor_ready.
- Latency:
  - An instruction captured at edge N appears at decoder_valid/dec_* after edge N.
  - Back-to-back throughput is 1 instruction per cycle while executor_ready = 1.
- Slot update at each edge, in priority order:
  1. flush: decoder_valid <= 0; nothing is captured.
  2. Capture: load all dec_* from the new instruction; decoder_valid <= 1. This covers both an empty slot and a simultaneous handoff.
  3. Handoff without capture: decoder_valid <= 0.
  4. Otherwise: hold. dec_* must stay bit-stable while decoder_valid && !executor_ready.
- Flush:
  - decoder_ready may be 1 during flush, but the fetch-side instruction is discarded.
  - Fetch re-requests at the new PC.
- Illegal (dec_op = 0, dec_illegal = 1, decoder_valid still asserted) when any of:
  - instr[1:0] != 2'b11.
  - Unknown opcode.
  - JALR with funct3 != 0.
  - BRANCH with funct3 = 2 or 3.
  - LOAD with funct3 = 3, 6 or 7.
  - STORE with funct3 > 2.
  - OP_IMM shifts with funct7 other than 0x00, or 0x20 for SRAI.
  - OP with funct7 not in {0x00, 0x20}, or funct7 = 0x20 with funct3 not in {0, 5}.
  - FENCE when ALLOW_FENCE = 0.
  - SYSTEM with funct3 = 4.
- For an illegal instruction: all register indices, dec_imm, dec_funct3 and dec_alt are 0; dec_pc is still captured.
- Immediates:
  - I: {{20{i[31]}}, i[31:20]}.
  - S: {{20{i[31]}}, i[31:25], i[11:7]}.
  - B: {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - U: {i[31:12], 12'b0}.
  - J: {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}.
- Decode is combinational from `instr` into the slot registers; no decode logic sits after the slot.
- Reset mid-operation: a held instruction is dropped. After `reset` deasserts, decoder_ready = 1.

Test Plan:
- Reset:
  - Stimulus: assert reset asynchronously mid-cycle with decoder_valid = 1.
  - Required: decoder_valid falls before the next edge; all dec_* = 0; decoder_ready = 1 after release.
- ADDI:
  - Stimulus: instr 0xFFB10093 (addi x1,x2,-5), pc 0x100.
  - Required, one cycle later: dec_op = 8, rs1 = 2, rd = 1, rs2 = 0, imm = 0xFFFFFFFB, dec_pc = 0x100, dec_illegal = 0.
- STORE and BRANCH:
  - Stimulus: 0x00532423 (sw x5,8(x6)).
  - Required: op = 7, rs1 = 6, rs2 = 5, rd = 0, imm = 8.
  - Stimulus: 0xFE000EE3 (beq x0,x0,-4).
  - Required: op = 5, imm = 0xFFFFFFFC.
- Stall:
  - Stimulus: executor_ready = 0 for 3 cycles with fetcher_valid = 1.
  - Required: decoder_ready = 0; dec_* unchanged; no second capture.
  - Stimulus: executor_ready returns to 1.
  - Required: the next instruction loads on that edge.
- Illegal:
  - Stimulus: instr 0x00000000.
  - Required: decoder_valid = 1, dec_op = 0, dec_illegal = 1.
  - Stimulus: 0x4000F033 (funct7 = 0x20, funct3 = 7).
  - Required: illegal.
- Flush:
  - Stimulus: flush together with fetcher_valid and executor_ready = 1.
  - Required: next cycle decoder_valid = 0, nothing captured.
  - Stimulus: flush while stalled.
  - Required: the held instruction is dropped.
